scan_seq_core: RTL

- Parametrised synchronous sequential core: an N-bit state register with its next-state logic, a Moore output, and a full-scan chain through every state flop.
- Generalises the two-state-bit test machine (next top bit = x & (state all-zero or all-one), lower bits shift down, z = OR of state) to N state bits.
- Adds scan shift/capture, a functional clock-enable and a saturating z-activity counter for tester observation.
- Sits as the device-under-test core in the scanned vs. non-scanned flip-flop test harness.

---
 rtl/scan_seq_core_if.sv | 27 ++
 rtl/scan_seq_core.sv | 60 ++++++
 2 files changed

// File: rtl/scan_seq_core_if.sv
// Bus bundle for scan_seq_core: functional and scan controls in, observe signals out.
interface scan_seq_core_if #(
    parameter int N     = 2,
    parameter int CNT_W = 8
);
    logic             x;
    logic             func_en;
    logic             scan_en;
    logic             scan_in;
    logic             cnt_clr;
    logic             scan_out;
    logic             z;
    logic [N-1:0]     state;
    logic [CNT_W-1:0] z_cnt;

    // Driver side (tester / harness)
    modport master (
        output x, func_en, scan_en, scan_in, cnt_clr,
        input  scan_out, z, state, z_cnt
    );

    // Core side
    modport slave (
        input  x, func_en, scan_en, scan_in, cnt_clr,
        output scan_out, z, state, z_cnt
    );
endinterface

// File: rtl/scan_seq_core.sv
// Scanned N-bit test state machine with Moore output z = |S and a
// saturating counter of functional cycles that saw z high.
module scan_seq_core #(
    parameter int N     = 2,
    parameter int CNT_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    scan_seq_core_if.slave  bus
);

    // Reject unsupported geometries at elaboration time.
    if (N < 2 || N > 32) begin : g_bad_n
        $error("scan_seq_core: N must be in 2..32");
    end
    if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt
        $error("scan_seq_core: CNT_W must be in 1..32");
    end

    logic [N-1:0]     s_q, s_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             top_bit;

    // The new top bit only sets when the machine is at either extreme value.
    assign top_bit = bus.x & ((s_q == '0) | (s_q == '1));

    // Next state: scan shift wins over functional update; otherwise hold.
    always_comb begin
        s_d   = s_q;
        cnt_d = cnt_q;
        if (bus.scan_en) begin
            s_d = {bus.scan_in, s_q[N-1:1]};
        end else if (bus.func_en) begin
            s_d = {top_bit, s_q[N-1:1]};
        end
        // Clear beats increment; only functional cycles with z high count.
        if (bus.cnt_clr) begin
            cnt_d = '0;
        end else if (!bus.scan_en && bus.func_en && (|s_q) && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State and counter registers, reset dominates everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_q   <= '0;
            cnt_q <= '0;
        end else begin
            s_q   <= s_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.state    = s_q;
    assign bus.z        = |s_q;
    assign bus.scan_out = s_q[0];
    assign bus.z_cnt    = cnt_q;

endmodule
